fp16_op_sched: RTL and testbench
================================

Name: fp16_op_sched

Overview:
- Round-robin scheduler that shares one multi-cycle FP16 add/multiply unit between NREQ requesters.
- Each accepted request is pre-classified (NaN/inf/zero). Special cases are resolved locally, without occupying the shared unit; ordinary operands are issued to the unit.
- Sits between the shader-side FP16 requesters and the FPU arithmetic core.
- Returns one tagged result at a time on a valid/ready response port.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester-id width, equal to clog2(NREQ).
- TIMEOUT, 15, maximum cycles spent in WAIT before the watchdog aborts the operation.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- req_a  in  16*NREQ  operand A, slice i belongs to requester i.
- req_b  in  16*NREQ  operand B, slice i belongs to requester i.
- req_op  in  NREQ  per-requester opcode: 0 = add, 1 = mul.
- fu_start  out  1  one-cycle start pulse to the shared unit.
- fu_a, fu_b  out  16 each  latched operands driven to the shared unit.
- fu_op  out  1  latched opcode driven to the shared unit.
- fu_done  in  1  one-cycle completion pulse from the shared unit.
- fu_result  in  16  shared-unit result, valid while fu_done is high.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_data  out  16  FP16 result.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_invalid  out  1  invalid-operation flag.
- rsp_timeout  out  1  watchdog-abort flag.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - All outputs are 0.
  - Round-robin pointer last_grant = NREQ-1, so requester 0 has highest priority first.
  - Operand and result registers are cleared.
- States: IDLE, CHECK, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready is combinational and one-hot: it selects the first requester with valid high, searching from last_grant+1 with wrap-around.
  - On a handshake (req_valid[i] & req_ready[i]): latch a, b, op and id=i; set last_grant=i; go to CHECK.
  - If no request is valid, req_ready=0 and the state is held.
- CHECK: operands are classified from the latched registers. Special cases, in priority order:
  - 1. Either operand NaN -> result 16'h7E00. rsp_invalid=1 if either operand is sNaN.
  - 2. add with inf and opposite-sign inf -> 7E00, invalid=1.
  - 3. add with any inf -> that inf.
  - 4. mul with inf and zero -> 7E00, invalid=1.
  - 5. mul with inf and anything else -> inf, sign = sa^sb.
  - 6. mul with zero and a finite operand -> zero, sign = sa^sb.
  - If any case applies, load the result and go to RESP (2 cycles from acceptance to rsp_valid).
  - Otherwise go to ISSUE.
- ISSUE:
  - fu_start=1 for exactly one cycle.
  - fu_a, fu_b, fu_op stay stable from ISSUE until WAIT exits.
  - Clear the watchdog counter; go to WAIT.
- WAIT:
  - On fu_done: latch fu_result, flags = 0, go to RESP.
  - Otherwise the counter increments. When the counter reaches TIMEOUT: result 7E00, rsp_timeout=1, go to RESP.
  - A fu_done arriving in the same cycle as the timeout wins.
- RESP:
  - rsp_valid=1, with data/id/flags held stable.
  - Return to IDLE on rsp_valid & rsp_ready.
  - rsp_valid drops the cycle after the handshake.
- Stray events: fu_done outside WAIT is ignored. A late fu_done after a timeout is ignored.
- Throughput: one operation in flight; no request is accepted outside IDLE.
- Fairness: a requester that keeps valid high is served within NREQ operations.
- Reset mid-operation: immediate abort. fu_start and rsp_valid fall asynchronously, the pending result is discarded and the pointer is reset.
- Subnormal operands are not special; they go to the unit.

Decomposition:
- Package fp16_pkg holds:
  - constants FP16_QNAN=16'h7E00, FP16_EXP_W=5, FP16_MAN_W=10;
  - OP_ADD=1'b0, OP_MUL=1'b1;
  - the state enum.
- Instantiate two copies of the existing FP16 classifier hp_class, one per latched operand.
- Put the round-robin picker in a sub-module rr_pick (req vector, last_grant -> one-hot grant and index).

Test Plan:
- Requester 1 sends add 3C00+4000, shared unit answers 4200 after 3 cycles -> fu_start pulses once with fu_a=3C00, fu_b=4000; rsp_data=4200, rsp_id=1, flags 0.
- All 4 requesters hold valid from reset -> grant order 0,1,2,3,0.
- req_ready is one-hot in every cycle.
- Special cases (fu_start must stay 0 in each):
  - mul 7C00*0000 -> rsp_data=7E00, invalid=1, rsp_valid 2 cycles after acceptance.
  - add 7C00+FC00 -> 7E00, invalid=1.
  - mul FC00*4000 -> FC00.
  - add 7C10+3C00 -> 7E00, invalid=1.
- Shared unit never asserts fu_done -> after 15 WAIT cycles rsp_data=7E00, rsp_timeout=1; a fu_done injected later causes no new response.
- rsp_ready held low 5 cycles -> rsp_valid, data and id stable; a request from another requester is not accepted until the response handshake.
- rst_n pulsed low during WAIT -> outputs 0 immediately; the next grant goes to requester 0; a stray fu_done is ignored.

Source files
------------

// File: rtl/fp16_pkg.sv
// rtl/fp16_pkg.sv - shared FP16 constants, opcodes and scheduler state encoding
package fp16_pkg;

    localparam logic [15:0] FP16_QNAN  = 16'h7E00;
    localparam int          FP16_EXP_W = 5;
    localparam int          FP16_MAN_W = 10;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ISSUE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/hp_class.sv
// rtl/hp_class.sv - FP16 operand classifier (NaN / signalling NaN / inf / zero / sign)
module hp_class
    import fp16_pkg::*;
(
    input  logic [15:0] x,
    output logic        is_nan,
    output logic        is_snan,
    output logic        is_inf,
    output logic        is_zero,
    output logic        sign
);

    logic [FP16_EXP_W-1:0] exp_f;
    logic [FP16_MAN_W-1:0] man_f;
    logic                  exp_max;

    assign exp_f   = x[FP16_MAN_W +: FP16_EXP_W];
    assign man_f   = x[FP16_MAN_W-1:0];
    assign exp_max = &exp_f;

    // The mantissa MSB is the quiet bit; a NaN with it clear is signalling.
    assign is_nan  = exp_max && (man_f != '0);
    assign is_snan = is_nan && !man_f[FP16_MAN_W-1];
    assign is_inf  = exp_max && (man_f == '0);
    assign is_zero = (exp_f == '0) && (man_f == '0);
    assign sign    = x[15];

endmodule

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin picker: first valid requester after last_grant, with wrap
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    logic [IDW-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(last_grant) + k) % NREQ);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/fp16_op_sched.sv
// rtl/fp16_op_sched.sv - round-robin scheduler sharing one FP16 add/mul unit, resolving
// IEEE special cases locally and guarding the unit with a watchdog.
module fp16_op_sched
    import fp16_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req_valid,
    output logic [NREQ-1:0]  req_ready,
    input  logic [16*NREQ-1:0] req_a,
    input  logic [16*NREQ-1:0] req_b,
    input  logic [NREQ-1:0]  req_op,
    output logic             fu_start,
    output logic [15:0]      fu_a,
    output logic [15:0]      fu_b,
    output logic             fu_op,
    input  logic             fu_done,
    input  logic [15:0]      fu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [15:0]      rsp_data,
    output logic [IDW-1:0]   rsp_id,
    output logic             rsp_invalid,
    output logic             rsp_timeout
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t         state_q, state_d;
    logic [IDW-1:0] last_q, last_d;
    logic [IDW-1:0] id_q, id_d;
    logic [15:0]    a_q, a_d, b_q, b_d, res_q, res_d;
    logic           op_q, op_d;
    logic           inv_q, inv_d, tmo_q, tmo_d;
    logic           start_q, start_d, rvalid_q, rvalid_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gidx;
    logic            gany;

    logic [15:0] a_vec [NREQ];
    logic [15:0] b_vec [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
        assign a_vec[gi] = req_a[16*gi +: 16];
        assign b_vec[gi] = req_b[16*gi +: 16];
    end

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_rr_pick (
        .req        (req_valid),
        .last_grant (last_q),
        .grant      (grant),
        .idx        (gidx),
        .any        (gany)
    );

    logic a_nan, a_snan, a_inf, a_zero, a_s;
    logic b_nan, b_snan, b_inf, b_zero, b_s;

    hp_class u_class_a (
        .x(a_q), .is_nan(a_nan), .is_snan(a_snan), .is_inf(a_inf), .is_zero(a_zero), .sign(a_s)
    );
    hp_class u_class_b (
        .x(b_q), .is_nan(b_nan), .is_snan(b_snan), .is_inf(b_inf), .is_zero(b_zero), .sign(b_s)
    );

    // Special-case resolution, first matching rule wins.
    logic        spec_hit, spec_inv;
    logic [15:0] spec_res;

    always_comb begin
        spec_hit = 1'b1;
        spec_inv = 1'b0;
        spec_res = FP16_QNAN;
        if (a_nan || b_nan) begin
            spec_inv = a_snan || b_snan;
        end else if (op_q == OP_ADD && a_inf && b_inf && (a_s != b_s)) begin
            spec_inv = 1'b1;
        end else if (op_q == OP_ADD && (a_inf || b_inf)) begin
            spec_res = a_inf ? a_q : b_q;
        end else if (op_q == OP_MUL && ((a_inf && b_zero) || (a_zero && b_inf))) begin
            spec_inv = 1'b1;
        end else if (op_q == OP_MUL && (a_inf || b_inf)) begin
            spec_res = {a_s ^ b_s, {FP16_EXP_W{1'b1}}, {FP16_MAN_W{1'b0}}};
        end else if (op_q == OP_MUL && (a_zero || b_zero)) begin
            spec_res = {a_s ^ b_s, 15'h0000};
        end else begin
            spec_hit = 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        id_d     = id_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        res_d    = res_q;
        inv_d    = inv_q;
        tmo_d    = tmo_q;
        rvalid_d = rvalid_q;
        cnt_d    = cnt_q;
        start_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (gany) begin
                    a_d     = a_vec[gidx];
                    b_d     = b_vec[gidx];
                    op_d    = req_op[gidx];
                    id_d    = gidx;
                    last_d  = gidx;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (spec_hit) begin
                    res_d    = spec_res;
                    inv_d    = spec_inv;
                    tmo_d    = 1'b0;
                    rvalid_d = 1'b1;
                    state_d  = RESP;
                end else begin
                    start_d = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (fu_done) begin
                    res_d    = fu_result;
                    inv_d    = 1'b0;
                    tmo_d    = 1'b0;
                    rvalid_d = 1'b1;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_d == CW'(TIMEOUT)) begin
                        res_d    = FP16_QNAN;
                        inv_d    = 1'b0;
                        tmo_d    = 1'b1;
                        rvalid_d = 1'b1;
                        state_d  = RESP;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_q   <= IDW'(NREQ - 1);
            id_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 1'b0;
            res_q    <= '0;
            inv_q    <= 1'b0;
            tmo_q    <= 1'b0;
            rvalid_q <= 1'b0;
            start_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            id_q     <= id_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            res_q    <= res_d;
            inv_q    <= inv_d;
            tmo_q    <= tmo_d;
            rvalid_q <= rvalid_d;
            start_q  <= start_d;
            cnt_q    <= cnt_d;
        end
    end

    assign req_ready   = (state_q == IDLE) ? grant : '0;
    assign fu_start    = start_q;
    assign fu_a        = a_q;
    assign fu_b        = b_q;
    assign fu_op       = op_q;
    assign rsp_valid   = rvalid_q;
    assign rsp_data    = res_q;
    assign rsp_id      = id_q;
    assign rsp_invalid = inv_q;
    assign rsp_timeout = tmo_q;

endmodule

// File: tb/tb_fp16_op_sched.sv
// tb/tb_fp16_op_sched.sv - self-checking bench for fp16_op_sched
module tb_fp16_op_sched;

    localparam int NREQ = 4;
    localparam int IDW = 2;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid, req_ready, req_op;
    logic [16*NREQ-1:0] req_a, req_b;
    logic              fu_start, fu_op, fu_done;
    logic [15:0]       fu_a, fu_b, fu_result;
    logic              rsp_valid, rsp_ready, rsp_invalid, rsp_timeout;
    logic [15:0]       rsp_data;
    logic [IDW-1:0]    rsp_id;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fp16_op_sched #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .fu_start(fu_start), .fu_a(fu_a), .fu_b(fu_b), .fu_op(fu_op),
        .fu_done(fu_done), .fu_result(fu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_invalid(rsp_invalid), .rsp_timeout(rsp_timeout)
    );

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [15:0] b;
        logic        op;
        int          lat;
        logic [15:0] fval;
        logic [15:0] ed;
        logic        ei;
        logic        et;
        logic        efu;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input int id, input logic [15:0] a, input logic [15:0] b,
                                input logic op, input int lat, input logic [15:0] fval,
                                input logic [15:0] ed, input logic ei, input logic et,
                                input logic efu);
        vec_t v;
        v.id = id; v.a = a; v.b = b; v.op = op; v.lat = lat; v.fval = fval;
        v.ed = ed; v.ei = ei; v.et = et; v.efu = efu;
        return v;
    endfunction

    function automatic logic f_nan(input logic [15:0] x);
        return (x[14:10] == 5'h1f) && (x[9:0] != 10'h0);
    endfunction
    function automatic logic f_snan(input logic [15:0] x);
        return f_nan(x) && !x[9];
    endfunction
    function automatic logic f_inf(input logic [15:0] x);
        return (x[14:10] == 5'h1f) && (x[9:0] == 10'h0);
    endfunction
    function automatic logic f_zero(input logic [15:0] x);
        return x[14:0] == 15'h0;
    endfunction

    // Reference: IEEE special-case rules, else the unit's answer if it arrives in time.
    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic op,
                         input int lat, input logic [15:0] fval,
                         output logic [15:0] d, output logic inv, output logic tmo,
                         output logic usefu);
        logic sx;
        sx = a[15] ^ b[15];
        d = 16'h7E00; inv = 1'b0; tmo = 1'b0; usefu = 1'b0;
        if (f_nan(a) || f_nan(b)) inv = f_snan(a) || f_snan(b);
        else if (op == 1'b0) begin
            if (f_inf(a) && f_inf(b) && a[15] != b[15]) inv = 1'b1;
            else if (f_inf(a)) d = a;
            else if (f_inf(b)) d = b;
            else usefu = 1'b1;
        end else begin
            if ((f_inf(a) && f_zero(b)) || (f_zero(a) && f_inf(b))) inv = 1'b1;
            else if (f_inf(a) || f_inf(b)) d = {sx, 15'h7C00};
            else if (f_zero(a) || f_zero(b)) d = {sx, 15'h0000};
            else usefu = 1'b1;
        end
        if (usefu) begin
            if (lat >= 1 && lat <= TIMEOUT) d = fval;
            else tmo = 1'b1;
        end
    endtask

    task automatic run_op(input string name, input int id, input logic [15:0] a,
                          input logic [15:0] b, input logic op, input int lat,
                          input logic [15:0] fval, input logic [15:0] ed,
                          input logic ei, input logic et, input logic efu);
        logic acc;
        logic got;
        int   starts, s, k, exp_k;
        req_a[16*id +: 16] = a;
        req_b[16*id +: 16] = b;
        req_op[id] = op;
        req_valid = '0;
        req_valid[id] = 1'b1;
        acc = 1'b0;
        for (int c = 0; c < 30 && !acc; c++) begin
            #1;
            acc = req_ready[id];
            @(negedge clk);
        end
        req_valid = '0;
        chk({name, ".accept"}, 32'(acc), 32'd1);
        if (!acc) return;
        starts = 0; s = -1; k = 1; got = 1'b0;
        while (k < 60 && !got) begin
            if (fu_start) begin
                starts++;
                s = k;
                chk({name, ".fu_a"}, 32'(fu_a), 32'(a));
                chk({name, ".fu_b"}, 32'(fu_b), 32'(b));
                chk({name, ".fu_op"}, 32'(fu_op), 32'(op));
            end
            if (rsp_valid) got = 1'b1;
            else begin
                fu_done = (s >= 0) && (lat > 0) && (k == s + lat);
                fu_result = fu_done ? fval : 16'hDEAD;
                @(negedge clk);
                fu_done = 1'b0;
                k++;
            end
        end
        exp_k = !efu ? 2 : (et ? TIMEOUT + 3 : lat + 3);
        chk({name, ".rsp_seen"}, 32'(got), 32'd1);
        chk({name, ".latency"}, 32'(k), 32'(exp_k));
        chk({name, ".data"}, 32'(rsp_data), 32'(ed));
        chk({name, ".id"}, 32'(rsp_id), 32'(id));
        chk({name, ".invalid"}, 32'(rsp_invalid), 32'(ei));
        chk({name, ".timeout"}, 32'(rsp_timeout), 32'(et));
        chk({name, ".starts"}, 32'(starts), 32'(efu));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({name, ".valid_drop"}, 32'(rsp_valid), 32'd0);
    endtask

    function automatic logic [15:0] pick_operand();
        logic s;
        s = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 9))
            0: return 16'h7C00;
            1: return 16'hFC00;
            2: return 16'h0000;
            3: return 16'h8000;
            4: return 16'h7E00;
            5: return 16'h7C01;
            6: return {s, 5'h00, 10'($urandom_range(1, 1023))};
            default: return {s, 5'($urandom_range(1, 30)), 10'($urandom)};
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL global_time_limit");
        $fatal(1);
    end

    initial begin
        int          got_idx;
        logic        found;
        int          order[5] = '{0, 1, 2, 3, 0};
        logic [15:0] ra, rb, rf, ed;
        logic        rop, ei, et, efu;
        int          rid, rlat;

        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_op = '0;
        fu_done = 1'b0; fu_result = '0; rsp_ready = 1'b0;

        // Reset state
        #12;
        chk("rst.req_ready", 32'(req_ready), 0);
        chk("rst.fu_start", 32'(fu_start), 0);
        chk("rst.fu_a", 32'(fu_a), 0);
        chk("rst.fu_b", 32'(fu_b), 0);
        chk("rst.fu_op", 32'(fu_op), 0);
        chk("rst.rsp_valid", 32'(rsp_valid), 0);
        chk("rst.rsp_data", 32'(rsp_data), 0);
        chk("rst.rsp_id", 32'(rsp_id), 0);
        chk("rst.flags", 32'({rsp_invalid, rsp_timeout}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fairness: all requesters hold valid, specials only so the unit stays idle
        for (int i = 0; i < NREQ; i++) begin
            req_a[16*i +: 16] = 16'h7C00;
            req_b[16*i +: 16] = 16'h0000;
        end
        req_op = '1;
        rsp_ready = 1'b1;
        req_valid = '1;
        for (int n = 0; n < 5; n++) begin
            found = 1'b0;
            for (int t = 0; t < 10 && !found; t++) begin
                #1;
                chk("rr.onehot", 32'($onehot0(req_ready)), 1);
                chk("rr.no_start", 32'(fu_start), 0);
                if (req_ready != '0) begin
                    found = 1'b1;
                    got_idx = 0;
                    for (int i = 0; i < NREQ; i++) if (req_ready[i]) got_idx = i;
                    chk($sformatf("rr.order%0d", n), 32'(got_idx), 32'(order[n]));
                end
                @(negedge clk);
            end
            chk($sformatf("rr.found%0d", n), 32'(found), 1);
        end
        req_valid = '0;
        repeat (4) @(negedge clk);
        rsp_ready = 1'b0;
        req_op = '0;

        // Directed vectors
        tbl.push_back(mk(1, 16'h3C00, 16'h4000, 1'b0, 3,  16'h4200, 16'h4200, 0, 0, 1));
        tbl.push_back(mk(2, 16'h7C00, 16'h0000, 1'b1, 3,  16'h1111, 16'h7E00, 1, 0, 0));
        tbl.push_back(mk(3, 16'h7C00, 16'hFC00, 1'b0, 3,  16'h1111, 16'h7E00, 1, 0, 0));
        tbl.push_back(mk(0, 16'hFC00, 16'h4000, 1'b1, 3,  16'h1111, 16'hFC00, 0, 0, 0));
        tbl.push_back(mk(1, 16'h7C10, 16'h3C00, 1'b0, 3,  16'h1111, 16'h7E00, 1, 0, 0));
        tbl.push_back(mk(2, 16'h7E00, 16'h3C00, 1'b0, 3,  16'h1111, 16'h7E00, 0, 0, 0));
        tbl.push_back(mk(3, 16'h3C00, 16'h7C00, 1'b0, 3,  16'h1111, 16'h7C00, 0, 0, 0));
        tbl.push_back(mk(0, 16'h8000, 16'h4000, 1'b1, 3,  16'h1111, 16'h8000, 0, 0, 0));
        tbl.push_back(mk(1, 16'h0000, 16'hFC00, 1'b1, 3,  16'h1111, 16'h7E00, 1, 0, 0));
        tbl.push_back(mk(2, 16'hFC00, 16'hFC00, 1'b1, 3,  16'h1111, 16'h7C00, 0, 0, 0));
        tbl.push_back(mk(3, 16'h0000, 16'h0000, 1'b0, 1,  16'h0000, 16'h0000, 0, 0, 1));
        tbl.push_back(mk(0, 16'h0001, 16'h3C00, 1'b1, 15, 16'h0001, 16'h0001, 0, 0, 1));
        tbl.push_back(mk(1, 16'h7D00, 16'hFE00, 1'b1, 3,  16'h1111, 16'h7E00, 1, 0, 0));
        tbl.push_back(mk(2, 16'h3C00, 16'h3C00, 1'b0, 0,  16'h1111, 16'h7E00, 0, 1, 1));
        foreach (tbl[i])
            run_op($sformatf("tbl%0d", i), tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].op,
                   tbl[i].lat, tbl[i].fval, tbl[i].ed, tbl[i].ei, tbl[i].et, tbl[i].efu);

        // Late fu_done after the timeout above must not produce a response
        fu_done = 1'b1; fu_result = 16'h4444;
        @(negedge clk);
        fu_done = 1'b0;
        for (int t = 0; t < 4; t++) begin
            chk("late_done.no_rsp", 32'({rsp_valid, fu_start}), 0);
            @(negedge clk);
        end

        // Backpressure: response held 5 cycles, competing request blocked
        req_a[16*2 +: 16] = 16'h7C00; req_b[16*2 +: 16] = 16'h0000; req_op[2] = 1'b1;
        req_a[16*3 +: 16] = 16'h7C00; req_b[16*3 +: 16] = 16'h3C00; req_op[3] = 1'b0;
        req_valid = 4'b0100;
        found = 1'b0;
        for (int t = 0; t < 10 && !found; t++) begin
            #1;
            found = req_ready[2];
            @(negedge clk);
        end
        chk("bp.accept2", 32'(found), 1);
        req_valid = 4'b1000;
        found = 1'b0;
        for (int t = 0; t < 10 && !found; t++) begin
            found = rsp_valid;
            if (!found) @(negedge clk);
        end
        chk("bp.rsp_seen", 32'(found), 1);
        for (int t = 0; t < 5; t++) begin
            #1;
            chk("bp.valid", 32'(rsp_valid), 1);
            chk("bp.data", 32'(rsp_data), 32'h7E00);
            chk("bp.id", 32'(rsp_id), 2);
            chk("bp.invalid", 32'(rsp_invalid), 1);
            chk("bp.blocked", 32'(req_ready), 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp.blocked_hs", 32'(req_ready), 0);
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        chk("bp.ready3", 32'(req_ready), 32'b1000);
        @(negedge clk);
        req_valid = '0;
        found = 1'b0;
        for (int t = 0; t < 10 && !found; t++) begin
            found = rsp_valid;
            if (!found) @(negedge clk);
        end
        chk("bp.rsp3_seen", 32'(found), 1);
        chk("bp.rsp3_data", 32'(rsp_data), 32'h7C00);
        chk("bp.rsp3_id", 32'(rsp_id), 3);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Reset asserted while the unit is busy
        req_a[16*1 +: 16] = 16'h3C00; req_b[16*1 +: 16] = 16'h3C00; req_op[1] = 1'b0;
        req_valid = 4'b0010;
        found = 1'b0;
        for (int t = 0; t < 10 && !found; t++) begin
            #1;
            found = req_ready[1];
            @(negedge clk);
        end
        req_valid = '0;
        chk("rw.accept", 32'(found), 1);
        found = 1'b0;
        for (int t = 0; t < 10 && !found; t++) begin
            found = fu_start;
            @(negedge clk);
        end
        chk("rw.started", 32'(found), 1);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rw.fu_start", 32'(fu_start), 0);
        chk("rw.rsp_valid", 32'(rsp_valid), 0);
        chk("rw.fu_a", 32'(fu_a), 0);
        chk("rw.fu_b", 32'(fu_b), 0);
        chk("rw.rsp_data", 32'(rsp_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        fu_done = 1'b1; fu_result = 16'h5555;
        @(negedge clk);
        fu_done = 1'b0;
        for (int t = 0; t < 3; t++) begin
            chk("rw.stray_done", 32'({rsp_valid, fu_start}), 0);
            @(negedge clk);
        end
        req_a[16*0 +: 16] = 16'h7C00; req_b[16*0 +: 16] = 16'h0000; req_op[0] = 1'b1;
        req_valid = 4'b0011;
        #1;
        chk("rw.grant0", 32'(req_ready), 32'b0001);
        @(negedge clk);
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (4) @(negedge clk);
        rsp_ready = 1'b0;

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            rid  = $urandom_range(0, NREQ - 1);
            ra   = pick_operand();
            rb   = pick_operand();
            rop  = 1'($urandom_range(0, 1));
            rlat = $urandom_range(0, TIMEOUT + 2);
            rf   = 16'($urandom);
            model(ra, rb, rop, rlat, rf, ed, ei, et, efu);
            run_op($sformatf("rnd%0d", i), rid, ra, rb, rop, rlat, rf, ed, ei, et, efu);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
